// File: rtl/rv32_pkg.sv
// Shared encodings for the rv32_core slice: opcodes, funct3 codes, and the
// control enums that the decoder hands to the datapath.
package rv32_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_W    = 3'b010;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port,
// x0 always reads zero and ignores writes.
module rv32_regfile
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic        we,
  input  logic [31:0] rd_data,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd_addr != 5'd0) begin
      regs[rd_addr] <= rd_data;
    end
  end

  assign rs1_data = (rs1_addr == 5'd0) ? '0 : regs[rs1_addr];
  assign rs2_data = (rs2_addr == 5'd0) ? '0 : regs[rs2_addr];

endmodule

// File: rtl/rv32_core.sv
// Single-cycle RV32I subset core: decode, ALU, immediate generation and
// next-PC selection are combinational; PC and rd update on the rising edge.
module rv32_core
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            intr,
  input  logic [XLEN-1:0] inst_in,
  input  logic [XLEN-1:0] Data_in,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] Addr_out,
  output logic [XLEN-1:0] Data_out,
  output logic            MemRW,
  output logic            MemRd
);

  logic [31:0] pc, next_pc, pc_plus4, pc_imm;
  logic [31:0] imm, rs1_val, rs2_val, alu_a, alu_b, alu_res, wb_data;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  imm_sel_e    imm_sel;
  alu_op_e     alu_op;
  wb_sel_e     wb_sel;
  logic        src_imm, a_pc, reg_we, mem_rd, mem_wr, branch, jump, jump_reg, take;

  // The interrupt request is a reserved input with no effect on core state.
  logic unused_intr;
  assign unused_intr = intr;

  assign opcode = inst_in[6:0];
  assign rd     = inst_in[11:7];
  assign f3     = inst_in[14:12];
  assign rs1    = inst_in[19:15];
  assign rs2    = inst_in[24:20];
  assign f7     = inst_in[31:25];

  rv32_regfile u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1),
    .rs2_addr (rs2),
    .rd_addr  (rd),
    .we       (reg_we && !rst),
    .rd_data  (wb_data),
    .rs1_data (rs1_val),
    .rs2_data (rs2_val)
  );

  // Unrecognised encodings fall through with every control inactive, i.e. a NOP.
  always_comb begin
    imm_sel  = IMM_I;
    alu_op   = ALU_ADD;
    wb_sel   = WB_ALU;
    src_imm  = 1'b0;
    a_pc     = 1'b0;
    reg_we   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    jump_reg = 1'b0;
    case (opcode)
      OPC_LUI: begin
        imm_sel = IMM_U; alu_op = ALU_PASSB; src_imm = 1'b1; reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U; a_pc = 1'b1; src_imm = 1'b1; reg_we = 1'b1;
      end
      OPC_JAL: begin
        imm_sel = IMM_J; jump = 1'b1; reg_we = 1'b1; wb_sel = WB_PC4;
      end
      OPC_JALR: if (f3 == 3'b000) begin
        src_imm = 1'b1; jump_reg = 1'b1; reg_we = 1'b1; wb_sel = WB_PC4;
      end
      OPC_BRANCH: if (f3 != 3'b010 && f3 != 3'b011) begin
        imm_sel = IMM_B; branch = 1'b1;
      end
      OPC_LOAD: if (f3 == F3_W) begin
        src_imm = 1'b1; reg_we = 1'b1; wb_sel = WB_MEM; mem_rd = 1'b1;
      end
      OPC_STORE: if (f3 == F3_W) begin
        imm_sel = IMM_S; src_imm = 1'b1; mem_wr = 1'b1;
      end
      OPC_OP_IMM: begin
        src_imm = 1'b1;
        alu_op  = alu_decode(f3, (f3 == F3_SR) && f7[5]);
        if (f3 == F3_SLL)     reg_we = (f7 == 7'h00);
        else if (f3 == F3_SR) reg_we = (f7 == 7'h00) || (f7 == 7'h20);
        else                  reg_we = 1'b1;
      end
      OPC_OP: begin
        alu_op = alu_decode(f3, f7[5]);
        reg_we = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == F3_ADD || f3 == F3_SR));
      end
      default: ;
    endcase
  end

  always_comb begin
    case (imm_sel)
      IMM_S:   imm = {{20{inst_in[31]}}, inst_in[31:25], inst_in[11:7]};
      IMM_B:   imm = {{19{inst_in[31]}}, inst_in[31], inst_in[7], inst_in[30:25],
                      inst_in[11:8], 1'b0};
      IMM_U:   imm = {inst_in[31:12], 12'b0};
      IMM_J:   imm = {{11{inst_in[31]}}, inst_in[31], inst_in[19:12], inst_in[20],
                      inst_in[30:21], 1'b0};
      default: imm = {{20{inst_in[31]}}, inst_in[31:20]};
    endcase
  end

  assign alu_a = a_pc ? pc : rs1_val;
  assign alu_b = src_imm ? imm : rs2_val;

  always_comb begin
    case (alu_op)
      ALU_SUB:   alu_res = alu_a - alu_b;
      ALU_SLL:   alu_res = alu_a << alu_b[4:0];
      ALU_SLT:   alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU:  alu_res = {31'b0, alu_a < alu_b};
      ALU_XOR:   alu_res = alu_a ^ alu_b;
      ALU_SRL:   alu_res = alu_a >> alu_b[4:0];
      ALU_SRA:   alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      ALU_OR:    alu_res = alu_a | alu_b;
      ALU_AND:   alu_res = alu_a & alu_b;
      ALU_PASSB: alu_res = alu_b;
      default:   alu_res = alu_a + alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      F3_BEQ:  take = (rs1_val == rs2_val);
      F3_BNE:  take = (rs1_val != rs2_val);
      F3_BLT:  take = ($signed(rs1_val) < $signed(rs2_val));
      F3_BGE:  take = ($signed(rs1_val) >= $signed(rs2_val));
      F3_BLTU: take = (rs1_val < rs2_val);
      F3_BGEU: take = (rs1_val >= rs2_val);
      default: take = 1'b0;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign pc_imm   = pc + imm;

  always_comb begin
    if (jump_reg)                   next_pc = {alu_res[31:1], 1'b0};
    else if (jump || (branch && take)) next_pc = pc_imm;
    else                            next_pc = pc_plus4;
  end

  always_comb begin
    case (wb_sel)
      WB_MEM:  wb_data = Data_in;
      WB_PC4:  wb_data = pc_plus4;
      default: wb_data = alu_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= next_pc;
  end

  assign pc_out   = pc;
  assign Addr_out = alu_res;
  assign Data_out = rs2_val;
  assign MemRW    = mem_wr && !rst;
  assign MemRd    = mem_rd && !rst;

endmodule

// File: tb/tb_rv32_core.sv
// Self-checking bench for rv32_core: a table of per-cycle instruction records
// with expected bus outputs, checked through a scoreboard queue.
module tb_rv32_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        intr;
  logic [31:0] inst_in, Data_in;
  logic [31:0] pc_out, Addr_out, Data_out;
  logic        MemRW, MemRd;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic        rst;
    logic [31:0] inst;
    logic [31:0] din;
    logic        chk_pc;
    logic [31:0] pc;
    logic        rw;
    logic        rd;
    logic        chk_addr;
    logic [31:0] addr;
    logic        chk_data;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  rv32_core #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .intr     (intr),
    .inst_in  (inst_in),
    .Data_in  (Data_in),
    .pc_out   (pc_out),
    .Addr_out (Addr_out),
    .Data_out (Data_out),
    .MemRW    (MemRW),
    .MemRd    (MemRd)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2);
    return {7'd0, rs2, 5'd0, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int off, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    logic [12:0] b;
    b = off[12:0];
    return {b[12], b[10:5], rs2, rs1, f3, b[4:1], b[11], 7'b1100011};
  endfunction

  function automatic vec_t mk(input logic r, input logic [31:0] inst, input logic [31:0] din,
                              input logic cp, input logic [31:0] pc, input logic rw,
                              input logic rd, input logic ca, input logic [31:0] addr,
                              input logic cd, input logic [31:0] data);
    vec_t v;
    v.rst = r; v.inst = inst; v.din = din; v.chk_pc = cp; v.pc = pc; v.rw = rw;
    v.rd = rd; v.chk_addr = ca; v.addr = addr; v.chk_data = cd; v.data = data;
    return v;
  endfunction

  function automatic vec_t nop_v(input logic [31:0] inst, input logic [31:0] pc,
                                 input logic [31:0] din);
    return mk(1'b0, inst, din, 1'b1, pc, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endfunction

  function automatic vec_t st_v(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] addr, input logic [31:0] data);
    return mk(1'b0, inst, 32'd0, 1'b1, pc, 1'b1, 1'b0, 1'b1, addr, 1'b1, data);
  endfunction

  function automatic vec_t ld_v(input logic [31:0] inst, input logic [31:0] pc,
                                input logic [31:0] din, input logic [31:0] addr);
    return mk(1'b0, inst, din, 1'b1, pc, 1'b0, 1'b1, 1'b1, addr, 1'b0, 32'd0);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    inst_in = v.inst;
    Data_in = v.din;
    intr    = 1'($urandom_range(0, 1));
    sb.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t v;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard[%0d]: actual=empty required=entry", idx);
    end else begin
      v = sb.pop_front();
      if (v.chk_pc)   cmp($sformatf("pc[%0d]", idx), pc_out, v.pc);
      cmp($sformatf("MemRW[%0d]", idx), {31'b0, MemRW}, {31'b0, v.rw});
      cmp($sformatf("MemRd[%0d]", idx), {31'b0, MemRd}, {31'b0, v.rd});
      if (v.chk_addr) cmp($sformatf("Addr[%0d]", idx), Addr_out, v.addr);
      if (v.chk_data) cmp($sformatf("Data[%0d]", idx), Data_out, v.data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Main program: each record is one retired instruction; stores expose registers.
    vecs.push_back(nop_v(32'h0000_7293, 32'd0, 32'd0));
    vecs.push_back(nop_v(32'h8888_8137, 32'd4, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd2), 32'd8, 32'd0, 32'h8888_8000));
    vecs.push_back(st_v(enc_sw(5'd5), 32'd12, 32'd0, 32'd0));
    vecs.push_back(nop_v(enc_i(12'h123, 5'd0, 3'd0, 5'd3, 7'h13), 32'd16, 32'd0));
    vecs.push_back(st_v(32'h0032_a223, 32'd20, 32'd4, 32'h0000_0123));
    vecs.push_back(ld_v(32'h01c0_2383, 32'd24, 32'h1234_5678, 32'd28));
    vecs.push_back(st_v(enc_sw(5'd7), 32'd28, 32'd0, 32'h1234_5678));
    vecs.push_back(nop_v(enc_i(12'h000, 5'd7, 3'd0, 5'd3, 7'h13), 32'd32, 32'd0));
    vecs.push_back(nop_v(32'h0033_8863, 32'd36, 32'd0));
    vecs.push_back(nop_v(32'h0010_0093, 32'd52, 32'd0));
    vecs.push_back(nop_v(32'hfe00_98e3, 32'd56, 32'd0));
    vecs.push_back(nop_v(32'hfe00_88e3, 32'd40, 32'd0));
    vecs.push_back(nop_v(32'h0080_006f, 32'd44, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd0), 32'd52, 32'd0, 32'd0));
    vecs.push_back(nop_v(32'hf65f_f06f, 32'd56, 32'd0));
    vecs.push_back(nop_v(32'h0080_00ef, 32'hFFFF_FF9C, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd1), 32'hFFFF_FFA4, 32'd0, 32'hFFFF_FFA0));
    vecs.push_back(nop_v(enc_i(12'h061, 5'd1, 3'd0, 5'd6, 7'h67), 32'hFFFF_FFA8, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd6), 32'd0, 32'd0, 32'hFFFF_FFAC));
    vecs.push_back(nop_v(32'h0010_0293, 32'd4, 32'd0));
    vecs.push_back(nop_v(32'h0012_9293, 32'd8, 32'd0));
    vecs.push_back(nop_v(enc_i(12'h000, 5'd0, 3'd0, 5'd6, 7'h13), 32'd12, 32'd0));
    vecs.push_back(nop_v(32'h4053_0433, 32'd16, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd8), 32'd20, 32'd0, 32'hFFFF_FFFE));
    vecs.push_back(nop_v(32'h0050_3733, 32'd24, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd14), 32'd28, 32'd0, 32'd1));
    vecs.push_back(nop_v(enc_r(7'h00, 5'd5, 5'd8, 3'd2, 5'd9), 32'd32, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd9), 32'd36, 32'd0, 32'd1));
    vecs.push_back(nop_v(enc_r(7'h20, 5'd5, 5'd8, 3'd5, 5'd11), 32'd40, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd11), 32'd44, 32'd0, 32'hFFFF_FFFF));
    vecs.push_back(nop_v(enc_r(7'h00, 5'd5, 5'd8, 3'd5, 5'd12), 32'd48, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd12), 32'd52, 32'd0, 32'h3FFF_FFFF));
    vecs.push_back(nop_v(32'h0000_1697, 32'd56, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd13), 32'd60, 32'd0, 32'h0000_1038));
    vecs.push_back(nop_v(32'h0000_000f, 32'd64, 32'd0));
    vecs.push_back(nop_v(32'h0000_0683, 32'd68, 32'hDEAD_BEEF));
    vecs.push_back(st_v(enc_sw(5'd13), 32'd72, 32'd0, 32'h0000_1038));
    vecs.push_back(nop_v(enc_b(8, 5'd5, 5'd8, 3'd4), 32'd76, 32'd0));
    vecs.push_back(nop_v(enc_b(8, 5'd5, 5'd8, 3'd6), 32'd84, 32'd0));
    vecs.push_back(nop_v(enc_b(-88, 5'd5, 5'd8, 3'd7), 32'd88, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd0), 32'd0, 32'd0, 32'd0));
    vecs.push_back(nop_v(enc_i(12'hFFF, 5'd8, 3'd4, 5'd15, 7'h13), 32'd4, 32'd0));
    vecs.push_back(st_v(enc_sw(5'd15), 32'd8, 32'd0, 32'd1));

    // Initial reset with a store on the bus: strobes must stay low.
    applyStimulus(mk(1'b1, enc_sw(5'd3), 32'd0, 1'b0, 32'd0, 1'b0, 1'b0,
                     1'b0, 32'd0, 1'b0, 32'd0));
    checkOutput(-1);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i);
    end

    // Reset mid-program: store, load and jump all suppressed, registers cleared.
    applyStimulus(mk(1'b1, enc_sw(5'd8), 32'd0, 1'b1, 32'd12, 1'b0, 1'b0,
                     1'b0, 32'd0, 1'b0, 32'd0));
    checkOutput(100);
    applyStimulus(mk(1'b1, 32'h01c0_2383, 32'h5555_AAAA, 1'b1, 32'd0, 1'b0, 1'b0,
                     1'b0, 32'd0, 1'b0, 32'd0));
    checkOutput(101);
    applyStimulus(mk(1'b1, 32'h0080_00ef, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0,
                     1'b0, 32'd0, 1'b0, 32'd0));
    checkOutput(102);
    applyStimulus(st_v(enc_sw(5'd1), 32'd0, 32'd0, 32'd0));
    checkOutput(103);
    applyStimulus(st_v(enc_sw(5'd8), 32'd4, 32'd0, 32'd0));
    checkOutput(104);
    applyStimulus(st_v(enc_sw(5'd31), 32'd8, 32'd0, 32'd0));
    checkOutput(105);
    applyStimulus(st_v(enc_sw(5'd2), 32'd12, 32'd0, 32'd0));
    checkOutput(106);

    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL scoreboard drain: actual=%0d required=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
